// File: rtl/cg_enable_ctrl.sv
// Activity-based enable controller for a dual-latch clock-gating cell.
// Sequences OFF -> WAKING -> ON -> IDLE_WAIT -> OFF with software overrides.
module cg_enable_ctrl #(
   parameter int unsigned IDLE_CYCLES   = 16,
   parameter int unsigned MIN_ON_CYCLES = 4,
   parameter int unsigned WAKE_CYCLES   = 2,
   parameter int unsigned SLEEP_CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   activity,
   input  logic                   wake_req,
   output logic                   wake_ack,
   input  logic                   force_on,
   input  logic                   sw_disable,
   output logic                   gate_en,
   output logic [1:0]             state_o,
   output logic [SLEEP_CNT_W-1:0] sleep_cnt
);

   typedef enum logic [1:0] {
      StOff      = 2'd0,
      StWaking   = 2'd1,
      StOn       = 2'd2,
      StIdleWait = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [7:0]             wk_cnt_q, wk_cnt_d;
   logic [7:0]             min_cnt_q, min_cnt_d;
   logic [7:0]             idle_cnt_q, idle_cnt_d;
   logic [SLEEP_CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
   logic                   gate_en_q;
   logic                   wake_ack_q, wake_ack_d;
   logic                   wake;

   assign wake = activity | wake_req | force_on;

   always_comb begin
      state_d     = state_q;
      wk_cnt_d    = wk_cnt_q;
      min_cnt_d   = min_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      sleep_cnt_d = sleep_cnt_q;

      if (sw_disable) begin
         // Forced off is not an idle event, so sleep_cnt is left alone.
         state_d = StOff;
      end else begin
         unique case (state_q)
            StOff: begin
               if (wake) begin
                  state_d  = StWaking;
                  wk_cnt_d = 8'(WAKE_CYCLES);
               end
            end
            StWaking: begin
               wk_cnt_d = wk_cnt_q - 8'd1;
               if (wk_cnt_q == 8'd1) begin
                  state_d   = StOn;
                  min_cnt_d = 8'(MIN_ON_CYCLES);
               end
            end
            StOn: begin
               if (min_cnt_q != 8'd0) begin
                  min_cnt_d = min_cnt_q - 8'd1;
               end else if (!wake) begin
                  // force_on is already part of wake.
                  state_d    = StIdleWait;
                  idle_cnt_d = 8'd1;
               end
            end
            StIdleWait: begin
               if (wake) begin
                  state_d    = StOn;
                  idle_cnt_d = 8'd0;
               end else if (idle_cnt_q == 8'(IDLE_CYCLES - 1)) begin
                  state_d    = StOff;
                  idle_cnt_d = 8'd0;
                  if (sleep_cnt_q != {SLEEP_CNT_W{1'b1}}) begin
                     sleep_cnt_d = sleep_cnt_q + 1'b1;
                  end
               end else begin
                  idle_cnt_d = idle_cnt_q + 8'd1;
               end
            end
            default: state_d = StOff;
         endcase
      end

      wake_ack_d = wake_req & ~sw_disable &
                   ((state_d == StOn) | (state_d == StIdleWait));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StOff;
         wk_cnt_q    <= 8'd0;
         min_cnt_q   <= 8'd0;
         idle_cnt_q  <= 8'd0;
         sleep_cnt_q <= '0;
         gate_en_q   <= 1'b0;
         wake_ack_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wk_cnt_q    <= wk_cnt_d;
         min_cnt_q   <= min_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         sleep_cnt_q <= sleep_cnt_d;
         gate_en_q   <= (state_d != StOff);
         wake_ack_q  <= wake_ack_d;
      end
   end

   assign gate_en   = gate_en_q;
   assign wake_ack  = wake_ack_q;
   assign state_o   = state_q;
   assign sleep_cnt = sleep_cnt_q;

endmodule
